// File: rtl/m65c02_irq_timer_pkg.sv
// Shared constants for the M65C02 interval timer / IRQ source.
// Holds the register offsets, the CTRL/STAT bit positions and the reset values.
package m65c02_irq_timer_pkg;

  // Register offsets (A[2:0])
  localparam logic [2:0] ADR_RLD_L = 3'd0;
  localparam logic [2:0] ADR_RLD_H = 3'd1;
  localparam logic [2:0] ADR_CTRL  = 3'd2;
  localparam logic [2:0] ADR_STAT  = 3'd3;
  localparam logic [2:0] ADR_PRE   = 3'd4;
  localparam logic [2:0] ADR_RSVD  = 3'd5;
  localparam logic [2:0] ADR_SWSET = 3'd6;
  localparam logic [2:0] ADR_SWCLR = 3'd7;

  // CTRL bits
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;

  // STAT bits
  localparam int STAT_TF  = 0;
  localparam int STAT_IRQ = 1;

  // Reset values
  localparam logic [7:0]  RST_BYTE = 8'h00;
  localparam logic [15:0] RST_WORD = 16'h0000;
  localparam logic        RST_BIT  = 1'b0;

endpackage

// File: rtl/m65c02_prescaler.sv
// Loadable prescaler down-counter.
// Ports: Clk/nRstO clock and async active-low reset; en enables counting;
// load restarts the count from pre; tick is high while en=1 and the count is 0.
module m65c02_prescaler #(
  parameter int pPreWidth = 8
) (
  input  logic                 Clk,
  input  logic                 nRstO,
  input  logic                 en,
  input  logic                 load,
  input  logic [pPreWidth-1:0] pre,
  output logic                 tick
);

  logic [pPreWidth-1:0] cnt;

  assign tick = en & (cnt == '0);

  always_ff @(posedge Clk or negedge nRstO) begin
    if (!nRstO)       cnt <= '0;
    else if (load)    cnt <= pre;
    else if (en)      cnt <= tick ? pre : cnt - pPreWidth'(1);
  end

endmodule

// File: rtl/m65c02_irq_timer.sv
// Memory-mapped interval timer and interrupt source for the M65C02 bus.
// Ports: Clk/nRstO bus clock and async active-low reset; Sel/Adr/WrStb/RdStb/DI
// bus access; DO combinational read data (0 when not selected); nIRQ_OE
// registered open-drain enable for nIRQ; TO one-cycle timeout pulse.
module m65c02_irq_timer
  import m65c02_irq_timer_pkg::*;
#(
  parameter int pCntWidth = 16,
  parameter int pPreWidth = 8
) (
  input  logic       Clk,
  input  logic       nRstO,
  input  logic       Sel,
  input  logic [2:0] Adr,
  input  logic       WrStb,
  input  logic       RdStb,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  output logic       nIRQ_OE,
  output logic       TO
);

  logic [pCntWidth-1:0] rld, cnt;
  logic [7:0]           hlat;
  logic [pPreWidth-1:0] pre;
  logic                 en, auto_rld, ie, tf, swirq;
  logic                 wr, rd, wr_rldh, en_rise, tick, timeout;

  assign wr      = Sel & WrStb;
  assign rd      = Sel & RdStb;
  assign wr_rldh = wr && (Adr == ADR_RLD_H);
  assign en_rise = wr && (Adr == ADR_CTRL) && DI[CTRL_EN] && !en;

  // A reload write discards a coincident tick, so it must also mask the timeout.
  assign timeout = tick && (cnt == '0) && !wr_rldh;

  m65c02_prescaler #(.pPreWidth(pPreWidth)) u_pre (
    .Clk   (Clk),
    .nRstO (nRstO),
    .en    (en),
    .load  (wr_rldh | en_rise),
    .pre   (pre),
    .tick  (tick)
  );

  always_ff @(posedge Clk or negedge nRstO) begin
    if (!nRstO) begin
      rld      <= RST_WORD;
      cnt      <= RST_WORD;
      hlat     <= RST_BYTE;
      pre      <= RST_BYTE;
      en       <= RST_BIT;
      auto_rld <= RST_BIT;
      ie       <= RST_BIT;
      tf       <= RST_BIT;
      swirq    <= RST_BIT;
      nIRQ_OE  <= RST_BIT;
      TO       <= RST_BIT;
    end else begin
      if (wr) begin
        case (Adr)
          ADR_RLD_L: rld[7:0] <= DI;
          ADR_RLD_H: rld[pCntWidth-1:8] <= DI;
          ADR_CTRL: begin
            en       <= DI[CTRL_EN];
            auto_rld <= DI[CTRL_AUTO];
            ie       <= DI[CTRL_IE];
          end
          ADR_PRE:   pre   <= DI;
          ADR_SWSET: swirq <= 1'b1;
          ADR_SWCLR: swirq <= 1'b0;
          default: ;
        endcase
      end

      // Counter: a reload write takes the new high byte straight from DI.
      if (wr_rldh)
        cnt <= {DI, rld[7:0]};
      else if (tick) begin
        if (cnt != '0)    cnt <= cnt - pCntWidth'(1);
        else if (auto_rld) cnt <= rld;
      end

      // One-shot timeout stops the timer, overriding a same-cycle CTRL write.
      if (timeout && !auto_rld) en <= 1'b0;

      // Set beats a same-cycle clear.
      if (timeout)
        tf <= 1'b1;
      else if (wr && (Adr == ADR_STAT) && DI[STAT_TF])
        tf <= 1'b0;

      // Snapshot the high byte with the low-byte read so a 16-bit read is coherent.
      if (rd && (Adr == ADR_RLD_L)) hlat <= cnt[pCntWidth-1:8];

      TO      <= timeout;
      nIRQ_OE <= (tf & ie) | swirq;
    end
  end

  always_comb begin
    DO = 8'h00;
    if (Sel) begin
      case (Adr)
        ADR_RLD_L: DO = cnt[7:0];
        ADR_RLD_H: DO = hlat;
        ADR_CTRL:  DO = {5'b0, ie, auto_rld, en};
        ADR_STAT:  DO = {6'b0, nIRQ_OE, tf};
        ADR_PRE:   DO = pre;
        default:   DO = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_m65c02_irq_timer.sv
// Self-checking bench for m65c02_irq_timer. Read data and timeout instants are
// queued as expectations when stimulus is issued and compared when observed.
module tb_m65c02_irq_timer;

  logic       Clk = 1'b0;
  logic       nRstO = 1'b0;
  logic       Sel = 1'b0, WrStb = 1'b0, RdStb = 1'b0;
  logic [2:0] Adr = 3'd0;
  logic [7:0] DI = 8'h00;
  logic [7:0] DO;
  logic       nIRQ_OE, TO;

  int vecs = 0;
  int errs = 0;
  int cyc_n = 0;
  logic [7:0] rd_q[$];
  int         to_q[$];

  m65c02_irq_timer dut (
    .Clk(Clk), .nRstO(nRstO), .Sel(Sel), .Adr(Adr), .WrStb(WrStb),
    .RdStb(RdStb), .DI(DI), .DO(DO), .nIRQ_OE(nIRQ_OE), .TO(TO)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc_n++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    Sel = 1'b1; WrStb = 1'b1; Adr = a; DI = d;
    step();
    Sel = 1'b0; WrStb = 1'b0; DI = 8'h00;
  endtask

  // Bus read: expected byte is queued when the access is issued, popped and
  // compared against DO inside the access cycle.
  task automatic rd(input string nm, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] e;
    rd_q.push_back(exp);
    Sel = 1'b1; RdStb = 1'b1; Adr = a;
    #1;
    e = rd_q.pop_front();
    vecs++;
    if (DO !== e) begin
      errs++;
      $display("FAIL %s: DO=%02h expected %02h", nm, DO, e);
    end
    step();
    Sel = 1'b0; RdStb = 1'b0;
  endtask

  task automatic test_reset();
    nRstO = 1'b0;
    repeat (3) step();
    vecs++;
    if (nIRQ_OE !== 1'b0 || TO !== 1'b0) begin
      errs++;
      $display("FAIL reset_outs: nIRQ_OE=%b TO=%b expected 0 0", nIRQ_OE, TO);
    end
    nRstO = 1'b1;
    step();
    for (int i = 0; i < 8; i++) rd($sformatf("reset_rd%0d", i), 3'(i), 8'h00);
    wr(3'd5, 8'hFF);
    rd("reserved_rd", 3'd5, 8'h00);
  endtask

  task automatic test_oneshot();
    wr(3'd4, 8'h00);
    wr(3'd0, 8'h03);
    wr(3'd1, 8'h00);
    wr(3'd2, 8'h05);
    for (int k = 1; k <= 3; k++) begin
      step();
      vecs++;
      if (TO !== 1'b0) begin
        errs++;
        $display("FAIL oneshot_to_early: cycle %0d TO=%b expected 0", k, TO);
      end
    end
    step();
    vecs++;
    if (TO !== 1'b1 || nIRQ_OE !== 1'b0) begin
      errs++;
      $display("FAIL oneshot_to: TO=%b nIRQ_OE=%b expected 1 0", TO, nIRQ_OE);
    end
    step();
    vecs++;
    if (TO !== 1'b0 || nIRQ_OE !== 1'b1) begin
      errs++;
      $display("FAIL oneshot_irq: TO=%b nIRQ_OE=%b expected 0 1", TO, nIRQ_OE);
    end
    rd("oneshot_ctrl", 3'd2, 8'h04);
    rd("oneshot_stat", 3'd3, 8'h03);
    rd("oneshot_cnt", 3'd0, 8'h00);
    wr(3'd3, 8'h01);
    vecs++;
    if (nIRQ_OE !== 1'b1) begin
      errs++;
      $display("FAIL oneshot_clr1: nIRQ_OE=%b expected 1", nIRQ_OE);
    end
    step();
    vecs++;
    if (nIRQ_OE !== 1'b0) begin
      errs++;
      $display("FAIL oneshot_clr2: nIRQ_OE=%b expected 0", nIRQ_OE);
    end
    rd("oneshot_stat_clr", 3'd3, 8'h00);
  endtask

  task automatic test_auto_reload();
    int t0, exp_t;
    logic irq_seen;
    irq_seen = 1'b0;
    wr(3'd4, 8'h01);
    wr(3'd0, 8'h02);
    wr(3'd1, 8'h00);
    wr(3'd2, 8'h03);
    t0 = cyc_n;
    for (int k = 1; k <= 5; k++) to_q.push_back(t0 + 6 * k);
    for (int n = 0; n < 32; n++) begin
      step();
      if (nIRQ_OE) irq_seen = 1'b1;
      if (TO) begin
        vecs++;
        if (to_q.size() == 0) begin
          errs++;
          $display("FAIL auto_to_extra: TO at cycle %0d, none expected", cyc_n - t0);
        end else begin
          exp_t = to_q.pop_front();
          if (cyc_n !== exp_t) begin
            errs++;
            $display("FAIL auto_to_time: TO at cycle %0d expected %0d", cyc_n - t0, exp_t - t0);
          end
        end
      end
    end
    vecs++;
    if (to_q.size() != 0) begin
      errs++;
      $display("FAIL auto_to_missing: %0d pulses missing expected 0", to_q.size());
    end
    vecs++;
    if (irq_seen !== 1'b0) begin
      errs++;
      $display("FAIL auto_irq: nIRQ_OE seen=%b expected 0", irq_seen);
    end
    to_q.delete();
    wr(3'd2, 8'h00);
    wr(3'd3, 8'h01);
    rd("auto_stat_clr", 3'd3, 8'h00);
  endtask

  task automatic test_coherent_read();
    wr(3'd4, 8'h03);
    wr(3'd0, 8'h00);
    wr(3'd1, 8'h12);
    wr(3'd2, 8'h01);
    repeat (3) step();
    // Low byte read just before the 0x1200 -> 0x11FF tick.
    rd("coh_lo_a", 3'd0, 8'h00);
    rd("coh_hi_a", 3'd1, 8'h12);
    rd("coh_lo_b", 3'd0, 8'hFF);
    rd("coh_hi_b", 3'd1, 8'h11);
    wr(3'd2, 8'h00);
  endtask

  task automatic test_collisions();
    wr(3'd4, 8'h00);
    wr(3'd0, 8'h01);
    wr(3'd1, 8'h00);
    wr(3'd2, 8'h01);
    step();
    wr(3'd3, 8'h01);  // lands on the timeout edge
    vecs++;
    if (TO !== 1'b1) begin
      errs++;
      $display("FAIL coll_to: TO=%b expected 1", TO);
    end
    rd("coll_tf_kept", 3'd3, 8'h01);
    wr(3'd3, 8'h01);
    rd("coll_tf_clr", 3'd3, 8'h00);

    wr(3'd0, 8'h09);
    wr(3'd1, 8'h00);
    wr(3'd2, 8'h01);
    repeat (2) step();
    wr(3'd1, 8'h00);  // lands on a tick edge
    rd("coll_rldh", 3'd0, 8'h09);
    wr(3'd2, 8'h00);
  endtask

  task automatic test_swirq();
    wr(3'd6, 8'h00);
    vecs++;
    if (nIRQ_OE !== 1'b0) begin
      errs++;
      $display("FAIL swset1: nIRQ_OE=%b expected 0", nIRQ_OE);
    end
    step();
    vecs++;
    if (nIRQ_OE !== 1'b1) begin
      errs++;
      $display("FAIL swset2: nIRQ_OE=%b expected 1", nIRQ_OE);
    end
    rd("swset_stat", 3'd3, 8'h02);
    wr(3'd7, 8'h00);
    vecs++;
    if (nIRQ_OE !== 1'b1) begin
      errs++;
      $display("FAIL swclr1: nIRQ_OE=%b expected 1", nIRQ_OE);
    end
    step();
    vecs++;
    if (nIRQ_OE !== 1'b0) begin
      errs++;
      $display("FAIL swclr2: nIRQ_OE=%b expected 0", nIRQ_OE);
    end
  endtask

  task automatic test_reset_mid();
    wr(3'd4, 8'h02);
    wr(3'd0, 8'h00);
    wr(3'd1, 8'h01);
    wr(3'd2, 8'h07);
    wr(3'd6, 8'h00);
    repeat (5) step();
    nRstO = 1'b0;
    #1;
    vecs++;
    if (nIRQ_OE !== 1'b0 || TO !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_outs: nIRQ_OE=%b TO=%b expected 0 0", nIRQ_OE, TO);
    end
    repeat (2) step();
    nRstO = 1'b1;
    step();
    rd("rstmid_ctrl", 3'd2, 8'h00);
    rd("rstmid_hlat", 3'd1, 8'h00);
    rd("rstmid_cnt", 3'd0, 8'h00);
    rd("rstmid_pre", 3'd4, 8'h00);
    rd("rstmid_stat", 3'd3, 8'h00);
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_auto_reload();
    test_coherent_read();
    test_collisions();
    test_swirq();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/m65c02_irq_timer.md
# m65c02_irq_timer

Memory-mapped interval timer and interrupt source for the M65C02 external bus. It sits between the core's address/data/strobe outputs and its `nIRQ` input, and replaces the simulation-only software IRQ latch. Registers are written and read through the core's bus cycles. The block drives an open-drain interrupt request from either a timer timeout or a software-set request bit.

## Interface
Parameters:
- `pCntWidth`, 16: width of the down-counter and reload register (fixed to 16; the register map assumes 2 bytes).
- `pPreWidth`, 8: width of the prescaler.

Ports:
- `Clk`  in  1  bus clock; the M65C02 `Phi2O` domain; all state changes on the rising edge.
- `nRstO`  in  1  reset, asynchronous, active-low.
- `Sel`  in  1  chip select, decoded externally from `A[15:3]`.
- `Adr`  in  3  register offset, `A[2:0]`.
- `WrStb`  in  1  one-`Clk` write strobe; qualified internally with `Sel`.
- `RdStb`  in  1  one-`Clk` read strobe; qualified with `Sel`; used only for read side effects.
- `DI`  in  8  write data.
- `DO`  out  8  read data; combinational from `Adr`; 0 when `Sel` is 0.
- `nIRQ_OE`  out  1  1 means drive `nIRQ` low; the top level builds the tri-state.
- `TO`  out  1  single-`Clk` pulse on each timeout.

## Operation
Register map (offset: name):
- 0: `RLD_L`. Write sets reload[7:0]. Read returns counter[7:0] and latches counter[15:8] into `HLAT`.
- 1: `RLD_H`. Write sets reload[15:8], loads counter from the full reload value, and reloads the prescaler. Read returns `HLAT`.
- 2: `CTRL`. Bit0 `EN`, bit1 `AUTO` (auto-reload), bit2 `IE`. Bits 7:3 read 0.
- 3: `STAT`. Bit0 `TF`, bit1 `nIRQ_OE`. Writing 1 to bit0 clears `TF`.
- 4: `PRE`. Prescale value P; the counter decrements once every P+1 `Clk` cycles.
- 5: reserved. Reads 0; writes are ignored.
- 6: `SWSET`. Any write sets `SWIRQ`.
- 7: `SWCLR`. Any write clears `SWIRQ`.

Counting and interrupt behaviour:
- A tick occurs when `EN`=1 and the prescaler count = 0. On a tick the prescaler reloads to P; otherwise it decrements.
- On a tick with counter ≠ 0, the counter decrements.
- On a tick with counter = 0 (timeout):
  - `TF` is set and `TO` pulses.
  - If `AUTO`=1, the counter loads reload.
  - If `AUTO`=0, `EN` clears and the counter holds at 0.
- `nIRQ_OE` is registered: next state = (`TF` & `IE`) | `SWIRQ`.

Boundary cases:
- Reload = 0 with `AUTO`=1 gives a timeout on every tick.
- P = 0 gives a tick on every `Clk`.
- A timeout and a `STAT` clear-write in the same cycle: set wins, so `TF` stays 1.
- A write to `RLD_H` in the same cycle as a tick: the load wins and the tick is discarded.
- Writing `CTRL.EN` 0→1 restarts the prescaler from P. The counter is not reloaded.
- `SWSET` and `SWCLR` are separate offsets, so they cannot collide.
- Reset asserted mid-count aborts the count and returns all state to reset values.

Reset values:
- reload, counter, `HLAT`, prescaler, P, `CTRL`, `TF`, `SWIRQ`: 0.
- `nIRQ_OE`, `TO`: 0.
- `DO`: 0.

## Timing
- Writes take effect at the `Clk` edge where `Sel`&`WrStb`=1. The register is readable on the next cycle.
- The first tick after a `RLD_H` write (or an `EN` rise) occurs P+1 cycles later.
- Timeout period = (reload+1)·(P+1) cycles.
- `TF` is visible 1 cycle after the timeout edge. `nIRQ_OE` asserts 1 cycle after `TF` (2 cycles after the timeout edge).
- `SWIRQ` reaches `nIRQ_OE` 2 cycles after the write edge: 1 cycle to set `SWIRQ`, 1 cycle through the `nIRQ_OE` register.
- `DO` is valid combinationally within the access cycle. The `HLAT` capture happens at the `RdStb` edge of the offset-0 read.
- `nIRQ_OE` deasserts 2 cycles after the `TF`-clear or `SWCLR` write edge.

## Structure
- Shared package holds:
  - register offset constants (`ADR_RLD_L` … `ADR_SWCLR`),
  - `CTRL`/`STAT` bit-position constants,
  - reset constants.
- One sub-module, `m65c02_prescaler`: loadable down-counter that emits a tick.
- The top level holds the register file, the counter, and the IRQ logic.

## Test plan
- Reset: hold `nRstO`=0 for 3 cycles, then read every offset → all reads return 0x00 and `nIRQ_OE`=0.
- One-shot: reload = 0x0003, P = 0, `CTRL` = 0x05 → `TO` pulses 4 cycles after `EN` is set, `EN` self-clears, and `nIRQ_OE`=1 two cycles after the `TO` edge. Write `STAT`=0x01 → `nIRQ_OE`=0 two cycles after the write edge.
- Auto-reload: reload = 0x0002, P = 1, `CTRL` = 0x03 → `TO` pulses every 6 cycles for 5 periods, and `nIRQ_OE` stays 0 because `IE`=0.
- Coherent read: counter running at 0x1200→0x11FF, read offset 0 then offset 1 → the high byte returned matches the low-byte snapshot, e.g. 0xFF then 0x11, never 0x12.
- Collisions:
  - `STAT` clear-write on the timeout cycle → `TF` remains 1.
  - `RLD_H` write on a tick cycle → counter equals reload, not reload−1.
- Software IRQ: write offset 6 → `nIRQ_OE`=1 after 2 cycles. Write offset 7 → `nIRQ_OE`=0 after 2 cycles. Assert `nRstO` mid-count → `EN`=0 and the counter is 0.
